// File: rtl/mem_bus_arbiter.sv
// Two-requester cache-line arbiter for the shared C2 memory bus.
// One requester owns the bus at a time. A write sends the command plus
// BEATS data beats, then turns the bus around and waits for RESPONSE.
// A read sends the command, turns the bus around, waits for RESPONSE and
// then captures BEATS data beats. An 8-bit watchdog ends a transaction
// with err set when no RESPONSE arrives.
module mem_bus_arbiter #(
   parameter int ADDR_W  = 14,
   parameter int DATA_W  = 16,
   parameter int BEATS   = 8,
   parameter int TIMEOUT = 255
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     req0,
   input  logic                     req1,
   input  logic                     we0,
   input  logic                     we1,
   input  logic [ADDR_W-1:0]        addr0,
   input  logic [ADDR_W-1:0]        addr1,
   input  logic [DATA_W*BEATS-1:0]  wline0,
   input  logic [DATA_W*BEATS-1:0]  wline1,
   output logic                     done0,
   output logic                     done1,
   output logic                     err0,
   output logic                     err1,
   output logic [DATA_W*BEATS-1:0]  rline,
   output logic [ADDR_W-1:0]        a2,
   output logic [1:0]               c2_out,
   output logic                     c2_oe,
   output logic [DATA_W-1:0]        d2_out,
   output logic                     d2_oe,
   input  logic [1:0]               c2_in,
   input  logic [DATA_W-1:0]        d2_in
);

   // Beat index width; kept at least 1 bit so a single-beat line still builds.
   localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
   localparam logic [7:0]    TO_LIM    = 8'(TIMEOUT);

   // C2 command codes
   localparam logic [1:0] C2_NOP  = 2'd0;
   localparam logic [1:0] C2_RESP = 2'd1;
   localparam logic [1:0] C2_RD   = 2'd2;
   localparam logic [1:0] C2_WR   = 2'd3;

   // Transaction states
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CMD   = 3'd1;
   localparam logic [2:0] S_WDATA = 3'd2;
   localparam logic [2:0] S_TURN  = 3'd3;
   localparam logic [2:0] S_WAIT  = 3'd4;
   localparam logic [2:0] S_RDATA = 3'd5;
   localparam logic [2:0] S_DONE  = 3'd6;

   logic [2:0]                   r_state;
   logic                         r_owner;   // requester that owns the bus
   logic                         r_last;    // requester granted most recently
   logic                         r_we;
   logic [ADDR_W-1:0]            r_addr;
   logic [BEATS-1:0][DATA_W-1:0] r_wline;
   logic [BEATS-1:0][DATA_W-1:0] r_rline;
   logic [BW-1:0]                r_beat;
   logic [7:0]                   r_cnt;
   logic                         r_err;

   logic                         w_any_req;
   logic                         w_win;
   logic [7:0]                   w_cnt_nxt;
   logic                         w_drive;
   logic                         w_done;

   // Round-robin pick: on a tie the requester not granted last wins.
   always_comb begin
      w_any_req = req0 | req1;
      w_win     = (req0 & req1) ? ~r_last : req1;
      w_cnt_nxt = r_cnt + 8'd1;
   end

   // Transaction sequencer; all request inputs are sampled only in IDLE.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_owner <= 1'b0;
         r_last  <= 1'b1;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wline <= '0;
         r_rline <= '0;
         r_beat  <= '0;
         r_cnt   <= '0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_any_req) begin
                  r_owner <= w_win;
                  r_we    <= w_win ? we1    : we0;
                  r_addr  <= w_win ? addr1  : addr0;
                  r_wline <= w_win ? wline1 : wline0;
                  r_beat  <= '0;
                  r_err   <= 1'b0;
                  r_state <= S_CMD;
               end
            end
            S_CMD: begin
               // Beat 0 of a write goes out with the command itself.
               if (r_we && (BEATS > 1)) begin
                  r_beat  <= BW'(1);
                  r_state <= S_WDATA;
               end else begin
                  r_state <= S_TURN;
               end
            end
            S_WDATA: begin
               if (r_beat == LAST_BEAT) begin
                  r_state <= S_TURN;
               end else begin
                  r_beat <= r_beat + BW'(1);
               end
            end
            S_TURN: begin
               r_cnt   <= '0;
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               r_cnt <= w_cnt_nxt;
               // A response in the final watchdog cycle still counts as success.
               if (c2_in == C2_RESP) begin
                  if (r_we) begin
                     r_state <= S_DONE;
                  end else begin
                     r_rline[0] <= d2_in;
                     if (BEATS > 1) begin
                        r_beat  <= BW'(1);
                        r_state <= S_RDATA;
                     end else begin
                        r_state <= S_DONE;
                     end
                  end
               end else if (w_cnt_nxt == TO_LIM) begin
                  r_err   <= 1'b1;
                  r_state <= S_DONE;
               end
            end
            S_RDATA: begin
               // The responder streams the remaining beats back to back.
               r_rline[r_beat] <= d2_in;
               if (r_beat == LAST_BEAT) begin
                  r_state <= S_DONE;
               end else begin
                  r_beat <= r_beat + BW'(1);
               end
            end
            S_DONE: begin
               r_last  <= r_owner;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Bus drive and completion decode; the bus is driven only in CMD and WDATA.
   always_comb begin
      w_drive = (r_state == S_CMD) || (r_state == S_WDATA);
      w_done  = (r_state == S_DONE);
      c2_oe   = w_drive;
      d2_oe   = w_drive & r_we;
      a2      = w_drive ? r_addr : '0;
      d2_out  = (w_drive & r_we) ? r_wline[r_beat] : '0;
      c2_out  = C2_NOP;
      if (r_state == S_CMD) begin
         c2_out = r_we ? C2_WR : C2_RD;
      end else if (r_state == S_WDATA) begin
         c2_out = C2_WR;
      end
      done0   = w_done & ~r_owner;
      done1   = w_done &  r_owner;
      err0    = w_done & ~r_owner & r_err;
      err1    = w_done &  r_owner & r_err;
      rline   = r_rline;
   end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, meaning line-address width, equal to the C2 address bus.
REQ-002 SHALL have parameter DATA_W, default 16, meaning C2 data width per beat.
REQ-003 SHALL have parameter BEATS, default 8, meaning beats per cache line (128-bit line).
REQ-004 SHALL have parameter TIMEOUT, default 255, meaning maximum cycles spent waiting for C2_RESPONSE.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have ports req0/req1, input, 1 bit each: requester line-transaction request, held until done.
REQ-008 SHALL have ports we0/we1, input, 1 bit each: 1 = write line, 0 = read line.
REQ-009 SHALL have ports addr0/addr1, input, ADDR_W each: line address.
REQ-010 SHALL have ports wline0/wline1, input, DATA_W*BEATS each: write line, beat k = bits [k*DATA_W +: DATA_W].
REQ-011 SHALL have ports done0/done1, output, 1 bit each: one-cycle completion pulse.
REQ-012 SHALL have ports err0/err1, output, 1 bit each: valid with done; 1 = timeout.
REQ-013 SHALL have port rline, output, DATA_W*BEATS: read line, valid in the done cycle, same beat packing.
REQ-014 SHALL have port a2, output, ADDR_W: C2 address.
REQ-015 SHALL have ports c2_out, output, 2 bits, and c2_oe, output, 1 bit: C2 command drive and enable.
REQ-016 SHALL have ports d2_out, output, DATA_W, and d2_oe, output, 1 bit: C2 data drive and enable.
REQ-017 SHALL have ports c2_in, input, 2 bits, and d2_in, input, DATA_W: sampled C2 bus; codes NOP=0, RESPONSE=1, READ_LINE=2, WRITE_LINE=3.

Function
REQ-018 SHALL implement FSM states IDLE, CMD, WDATA, TURN, WAIT, RDATA, DONE.
REQ-019 SHALL arbitrate in IDLE round-robin: with both requests, the requester not granted last wins; last-grant resets to 1, so requester 0 wins first.
REQ-020 SHALL latch winner, we, addr and wline on leaving IDLE; input changes during the transaction SHALL be ignored.
REQ-021 SHALL in CMD (1 cycle) drive c2_oe=1, a2=addr, c2_out=READ_LINE or WRITE_LINE; for writes d2_oe=1, d2_out=beat 0.
REQ-022 SHALL for writes go CMD->WDATA, driving beats 1..BEATS-1 on consecutive cycles with c2_out=WRITE_LINE, then go to TURN.
REQ-023 SHALL for reads go CMD->TURN.
REQ-024 SHALL in TURN (1 cycle) drive c2_oe=d2_oe=0 and clear the timeout counter, then enter WAIT.
REQ-025 SHALL in WAIT increment an 8-bit counter each cycle; c2_in==RESPONSE SHALL exit WAIT: writes go to DONE, reads capture d2_in as beat 0 and enter RDATA.
REQ-026 SHALL in RDATA capture beats 1..BEATS-1 on consecutive cycles, then go to DONE.
REQ-027 SHALL go to DONE with err=1 when the counter reaches TIMEOUT without a response; rline contents are then don't-care.
REQ-028 SHALL in DONE (1 cycle) pulse done/err of the owner only, update last-grant, and return to IDLE; a still-asserted request SHALL be rearbitrated next cycle.
REQ-029 SHALL keep c2_oe=d2_oe=0 in IDLE, TURN, WAIT, RDATA and DONE; the bus SHALL never be driven while waiting for the response.
REQ-030 SHALL ignore c2_in outside WAIT and RDATA.
REQ-031 SHALL give a read latency, request-to-done, of 1 (arb) + 1 (CMD) + 1 (TURN) + W + BEATS + 1 cycles, where W = WAIT cycles before RESPONSE.

Reset
REQ-032 SHALL on reset low immediately enter IDLE with c2_oe=d2_oe=0, done*=err*=0, rline=0, a2=0, c2_out=NOP, d2_out=0 and last-grant=1.
REQ-033 SHALL on reset mid-transaction abandon it with no done pulse; the requester re-requests.

Verification
REQ-034 SHALL cover: req0 read addr=0x12A; responder gives RESPONSE after 5 cycles with beats 0x0001..0x0008 -> a2=0x12A with READ_LINE for 1 cycle, done0 with rline=0x0008_0007_..._0001 and err0=0.
REQ-035 SHALL cover: req1 write addr=0x3, wline beats 0xA0..0xA7 -> 8 consecutive driven cycles (WRITE_LINE, d2_out 0xA0..0xA7), release, RESPONSE -> done1, err1=0.
REQ-036 SHALL cover: req0 and req1 asserted together and held -> grant order 0,1,0,1, with no bus overlap between transactions.
REQ-037 SHALL cover: read with no responder -> c2_oe=0 throughout WAIT, done0 with err0=1 exactly TIMEOUT cycles after WAIT entry.
REQ-038 SHALL cover: reset asserted during WDATA beat 4 -> outputs at reset values immediately, no done pulse, next grant to requester 0.
